processor_pio_led_dimmer: RTL and testbench

- Sits directly downstream of the 4-bit Avalon PIO output port and consumes its out_port value as a brightness target.
- Drives one LED (or LED bank enable) with PWM. Duty ramps gradually toward the target, so software writes produce soft fades, not steps.
- Runs in the processor system clock domain. No bus interface; the PIO remains the only software-visible register.

---
 rtl/processor_pio_pkg.sv | 14 +
 rtl/processor_pio_led_dimmer_if.sv | 16 +
 rtl/processor_tick_gen.sv | 27 ++
 rtl/processor_pio_led_dimmer.sv | 75 +++++++
 tb/tb_processor_pio_led_dimmer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/processor_pio_pkg.sv
// Shared constants and helpers for the PIO-driven LED blocks.
// Brightness width default and PWM period arithmetic live here so later blocks agree.
package processor_pio_pkg;

  localparam int LEVEL_W_DEF = 4;

  // A level of w bits spans 0..2^w-1, so one PWM period is 2^w-1 ticks long.
  function automatic int pwm_period(input int w);
    return (1 << w) - 1;
  endfunction

  localparam int MAX_LEVEL = pwm_period(LEVEL_W_DEF);

endpackage

// File: rtl/processor_pio_led_dimmer_if.sv
// Signal bundle between the PIO out_port side and the LED dimmer.
interface processor_pio_led_dimmer_if
  import processor_pio_pkg::*;
#(
  parameter int LEVEL_W = LEVEL_W_DEF
);

  logic [LEVEL_W-1:0] level_in;
  logic               pwm_out;
  logic [LEVEL_W-1:0] current_level;
  logic               settled;

  modport master (output level_in, input pwm_out, current_level, settled);
  modport slave  (input level_in, output pwm_out, current_level, settled);

endinterface

// File: rtl/processor_tick_gen.sv
// Free-running prescaler: one-cycle tick every PRESCALE clock cycles.
module processor_tick_gen #(
  parameter int PRESCALE = 50
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] prescale_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_cnt <= '0;
    end else if (prescale_cnt == LAST) begin
      prescale_cnt <= '0;
    end else begin
      prescale_cnt <= prescale_cnt + 1'b1;
    end
  end

  assign tick = (prescale_cnt == LAST);

endmodule

// File: rtl/processor_pio_led_dimmer.sv
// PWM LED dimmer that fades its duty one LSB at a time toward the PIO target level.
module processor_pio_led_dimmer
  import processor_pio_pkg::*;
#(
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int PRESCALE   = 50,
  parameter int RAMP_TICKS = 16
) (
  input logic                       clk,
  input logic                       reset,
  processor_pio_led_dimmer_if.slave bus
);

  localparam logic [LEVEL_W-1:0] PWM_LAST = LEVEL_W'(pwm_period(LEVEL_W) - 1);
  localparam int                 RAMP_W   = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

  logic               tick;
  logic               period_end;
  logic               step;
  logic [LEVEL_W-1:0] target_q;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic [LEVEL_W-1:0] level_q;
  logic               pwm_q;

  processor_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign period_end = tick && (pwm_cnt == PWM_LAST);
  assign step       = period_end && (ramp_cnt == RAMP_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= '0;
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else begin
      target_q <= bus.level_in;
      if (tick) begin
        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      end
      if (period_end) begin
        ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + 1'b1;
      end
    end
  end

  // Level moves only on a period boundary, so every PWM period is drawn at one duty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_q <= (pwm_cnt < level_q);
      if (step) begin
        if (level_q < target_q) begin
          level_q <= level_q + 1'b1;
        end else if (level_q > target_q) begin
          level_q <= level_q - 1'b1;
        end
      end
    end
  end

  assign bus.pwm_out       = pwm_q;
  assign bus.current_level = level_q;
  assign bus.settled       = (level_q == target_q);

endmodule

// File: tb/tb_processor_pio_led_dimmer.sv
// Directed bench for the LED dimmer: main build (PRESCALE=2, RAMP_TICKS=2) plus an edge build (1/1).
module tb_processor_pio_led_dimmer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  processor_pio_led_dimmer_if #(.LEVEL_W(4)) if0 ();
  processor_pio_led_dimmer_if #(.LEVEL_W(4)) if1 ();

  processor_pio_led_dimmer #(
    .LEVEL_W    (4),
    .PRESCALE   (2),
    .RAMP_TICKS (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  processor_pio_led_dimmer #(
    .LEVEL_W    (4),
    .PRESCALE   (1),
    .RAMP_TICKS (1)
  ) dut_edge (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(input string name, input int got, input int want);
    failures++;
    $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic do_reset(input logic [3:0] lvl);
    @(negedge clk);
    if0.level_in = lvl;
    if1.level_in = 4'd0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Samples 61 falling edges: highs over the first 60, rising transitions over all 60 gaps.
  task automatic measure_pwm(input int n, output int highs, output int rises);
    logic prev;
    highs = 0;
    rises = 0;
    @(negedge clk);
    prev = if0.pwm_out;
    for (int i = 0; i < n; i++) begin
      if (prev === 1'b1) highs++;
      @(negedge clk);
      if (prev === 1'b0 && if0.pwm_out === 1'b1) rises++;
      prev = if0.pwm_out;
    end
  endtask

  task automatic wait_settled(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (if0.settled === 1'b1 && if0.current_level === if0.level_in) ok = 1;
    end
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    if0.level_in = 4'd9;
    if1.level_in = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (if0.current_level !== 4'd0) fail("reset_async_level", int'(if0.current_level), 0);
    checks++; if (if0.pwm_out !== 1'b0) fail("reset_async_pwm", int'(if0.pwm_out), 0);
    checks++; if (if0.settled !== 1'b1) fail("reset_settled", int'(if0.settled), 1);
    lows = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if0.pwm_out === 1'b0) lows++;
    end
    checks++; if (lows != 3) fail("reset_pwm_held_low", lows, 3);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (if0.pwm_out !== 1'b0) fail("post_reset_pwm", int'(if0.pwm_out), 0);
    checks++; if (if0.current_level !== 4'd0) fail("post_reset_level", int'(if0.current_level), 0);
    checks++; if (if0.settled !== 1'b0) fail("post_reset_settled", int'(if0.settled), 0);
  endtask

  task automatic test_ramp_up();
    int  prev, cur, last_chg, n_chg, lows;
    bit  done;
    do_reset(4'd0);
    if0.level_in = 4'd15;
    prev = 0; last_chg = 0; n_chg = 0; done = 0;
    for (int cyc = 1; cyc <= 1000 && !done; cyc++) begin
      @(negedge clk);
      cur = int'(if0.current_level);
      checks++; if (if0.settled !== (cur == 15)) fail("ramp_settled", int'(if0.settled), int'(cur == 15));
      if (cur != prev) begin
        checks++; if (cur != prev + 1) fail("ramp_step_size", cur, prev + 1);
        if (n_chg == 0) begin
          checks++; if (cyc > 61) fail("ramp_first_step", cyc, 61);
        end else begin
          checks++; if (cyc - last_chg != 60) fail("ramp_step_gap", cyc - last_chg, 60);
        end
        n_chg++;
        last_chg = cyc;
        prev = cur;
        if (cur == 15) begin
          done = 1;
          checks++; if (cyc > 961) fail("ramp_total_time", cyc, 961);
        end
      end
    end
    checks++; if (!done) fail("ramp_timeout", prev, 15);
    @(negedge clk);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if0.pwm_out !== 1'b1) lows++;
    end
    checks++; if (lows != 0) fail("full_level_low_cycles", lows, 0);
  endtask

  task automatic test_duty();
    int highs, rises;
    bit ok;
    if0.level_in = 4'd5;
    wait_settled(1500, ok);
    checks++; if (!ok) fail("duty5_settle_timeout", int'(if0.current_level), 5);
    repeat (2) @(negedge clk);
    measure_pwm(60, highs, rises);
    checks++; if (highs != 20) fail("duty5_high_clks", highs, 20);
    checks++; if (rises != 2) fail("duty5_pulses", rises, 2);
    if0.level_in = 4'd0;
    wait_settled(1500, ok);
    checks++; if (!ok) fail("duty0_settle_timeout", int'(if0.current_level), 0);
    repeat (2) @(negedge clk);
    measure_pwm(60, highs, rises);
    checks++; if (highs != 0) fail("duty0_high_clks", highs, 0);
  endtask

  task automatic test_reversal();
    int prev, cur, last_chg, n_chg, max_lvl;
    bit reversed, done;
    if0.level_in = 4'd12;
    prev = int'(if0.current_level);
    last_chg = 0; n_chg = 0; max_lvl = prev; reversed = 0; done = 0;
    for (int cyc = 1; cyc <= 2000 && !done; cyc++) begin
      @(negedge clk);
      cur = int'(if0.current_level);
      if (cur != prev) begin
        checks++; if (cur != prev + 1 && cur != prev - 1) fail("rev_step_size", cur, prev);
        if (n_chg > 0) begin
          checks++; if (cyc - last_chg != 60) fail("rev_step_gap", cyc - last_chg, 60);
        end
        n_chg++;
        last_chg = cyc;
        prev = cur;
      end
      if (cur > max_lvl) max_lvl = cur;
      if (!reversed && cur == 6) begin
        if0.level_in = 4'd2;
        reversed = 1;
      end
      if (reversed && cur == 2 && if0.settled === 1'b1) done = 1;
    end
    checks++; if (!done) fail("rev_timeout", prev, 2);
    checks++; if (max_lvl > 7) fail("rev_overshoot", max_lvl, 7);
    checks++; if (max_lvl < 6) fail("rev_peak_reached", max_lvl, 6);
  endtask

  task automatic test_hold();
    int highs, rises, bad;
    bit ok;
    if0.level_in = 4'd8;
    wait_settled(1500, ok);
    checks++; if (!ok) fail("hold_settle_timeout", int'(if0.current_level), 8);
    repeat (2) @(negedge clk);
    bad = 0;
    highs = 0;
    rises = 0;
    begin
      logic prev;
      prev = if0.pwm_out;
      for (int i = 0; i < 990; i++) begin
        if (prev === 1'b1) highs++;
        @(negedge clk);
        if (if0.current_level !== 4'd8 || if0.settled !== 1'b1) bad++;
        if (prev === 1'b0 && if0.pwm_out === 1'b1) rises++;
        prev = if0.pwm_out;
      end
    end
    checks++; if (bad != 0) fail("hold_level_disturbed", bad, 0);
    checks++; if (highs != 528) fail("hold_high_clks", highs, 528);
    checks++; if (rises != 33) fail("hold_periods", rises, 33);
  endtask

  task automatic test_edge_params();
    int prev, cur, last_chg, n_chg, lows;
    bit done;
    do_reset(4'd0);
    if1.level_in = 4'd15;
    prev = 0; last_chg = 0; n_chg = 0; done = 0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      cur = int'(if1.current_level);
      if (cur != prev) begin
        checks++; if (cur != prev + 1) fail("edge_step_size", cur, prev + 1);
        if (n_chg == 0) begin
          checks++; if (cyc > 16) fail("edge_first_step", cyc, 16);
        end else begin
          checks++; if (cyc - last_chg != 15) fail("edge_step_gap", cyc - last_chg, 15);
        end
        n_chg++;
        last_chg = cyc;
        prev = cur;
        if (cur == 15) begin
          done = 1;
          checks++; if (cyc > 240) fail("edge_total_time", cyc, 240);
        end
      end
    end
    checks++; if (!done) fail("edge_timeout", prev, 15);
    checks++; if (if1.settled !== 1'b1) fail("edge_settled", int'(if1.settled), 1);
    @(negedge clk);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if1.pwm_out !== 1'b1) lows++;
    end
    checks++; if (lows != 0) fail("edge_full_low_cycles", lows, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    if0.level_in = 4'd0;
    if1.level_in = 4'd0;
    test_reset();
    test_ramp_up();
    test_duty();
    test_reversal();
    test_hold();
    test_edge_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
